l2_stub: RTL and testbench



---
 rtl/l2_stub_if.sv | 50 +++++
 rtl/l2_stub.sv | 179 +++++++++++++++++
 tb/tb_l2_stub.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/l2_stub_if.sv
// ---------------------------------------------------------------------------
// l2_stub_if
//
// Purpose : Bundles the line-fill request/response channel between a cache
//           miss path (master) and the L2 stub (slave).
//
// Signals :
//   req_valid  master->slave  cache presents a line-fill request
//   add_in     master->slave  requested byte address (32 bits)
//   req_ready  slave->master  stub can accept a request this cycle
//   resp_valid slave->master  d_out/add_out carry a valid line
//   resp_ready master->slave  cache consumes the response this cycle
//   d_out      slave->master  64-byte line (512 bits)
//   add_out    slave->master  line-aligned address of the returned line
//   req_count  slave->master  saturating count of accepted requests
// ---------------------------------------------------------------------------
interface l2_stub_if;
  logic         req_valid;
  logic [31:0]  add_in;
  logic         req_ready;
  logic         resp_valid;
  logic         resp_ready;
  logic [511:0] d_out;
  logic [31:0]  add_out;
  logic [15:0]  req_count;

  // Cache side: issues requests, consumes responses.
  modport master (
    output req_valid,
    output add_in,
    input  req_ready,
    input  resp_valid,
    output resp_ready,
    input  d_out,
    input  add_out,
    input  req_count
  );

  // Stub side: accepts requests, produces responses.
  modport slave (
    input  req_valid,
    input  add_in,
    output req_ready,
    output resp_valid,
    input  resp_ready,
    output d_out,
    output add_out,
    output req_count
  );
endinterface : l2_stub_if

// File: rtl/l2_stub.sv
// ---------------------------------------------------------------------------
// l2_stub
//
// Purpose : Behavioural stand-in for an L2 cache. Accepts one line-fill
//           request at a time, waits a fixed LATENCY, then returns a
//           synthetic 64-byte line whose 32-bit words are derived from the
//           line address (word i = (line_base + 4*i) ^ SEED). No pipelining:
//           a new request is only taken once the previous response has been
//           consumed.
//
// Parameters:
//   LATENCY  cycles from request accept to resp_valid (1..15, 0 acts as 1)
//   SEED     XOR mask applied to every generated data word
//
// Ports   :
//   i_clk    single clock, rising edge
//   i_rst_n  asynchronous active-low reset
//   s_bus    l2_stub_if.slave request/response channel (see l2_stub_if.sv)
//
// Every output on s_bus is driven straight from a flop, so there is no
// combinational path from req_valid/resp_ready to any output.
// ---------------------------------------------------------------------------
module l2_stub #(
  parameter int unsigned LATENCY = 4,
  parameter logic [31:0] SEED    = 32'h0000_0000
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  l2_stub_if.slave       s_bus
);

  // Clamp the latency into the range the 4-bit wait counter can express;
  // a latency of zero is treated as one cycle.
  localparam int unsigned LAT_EFF  = (LATENCY == 0) ? 1 :
                                     ((LATENCY > 15) ? 15 : LATENCY);
  localparam logic [3:0]  CNT_LOAD = 4'(LAT_EFF - 1);

  localparam int unsigned WORDS = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // -------------------------------------------------------------------------
  // State and output registers
  // -------------------------------------------------------------------------
  state_t       r_state;
  logic [3:0]   r_cnt;
  logic [31:0]  r_line_base;
  logic [15:0]  r_req_count;

  logic         r_req_ready;
  logic         r_resp_valid;
  logic [511:0] r_d_out;
  logic [31:0]  r_add_out;

  // -------------------------------------------------------------------------
  // Next-state values
  // -------------------------------------------------------------------------
  state_t       w_state_next;
  logic [3:0]   w_cnt_next;
  logic [31:0]  w_line_base_next;
  logic [15:0]  w_req_count_next;

  logic         w_req_ready_next;
  logic         w_resp_valid_next;
  logic [511:0] w_d_out_next;
  logic [31:0]  w_add_out_next;

  logic [511:0] w_line_data;

  // -------------------------------------------------------------------------
  // Synthetic line generator. Word i is the byte address of that word within
  // the line, XOR-ed with SEED. The add wraps modulo 2^32 on purpose so a
  // line at the top of the address space simply rolls over.
  // -------------------------------------------------------------------------
  for (genvar gi = 0; gi < WORDS; gi++) begin : g_word
    assign w_line_data[32*gi +: 32] = (r_line_base + 32'(4 * gi)) ^ SEED;
  end

  // -------------------------------------------------------------------------
  // Next-state / next-output logic
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_next     = r_state;
    w_cnt_next       = r_cnt;
    w_line_base_next = r_line_base;
    w_req_count_next = r_req_count;

    unique case (r_state)
      ST_IDLE: begin
        // r_req_ready is 0 on the first cycle after reset release, which
        // keeps that cycle from accepting a request.
        if (s_bus.req_valid && r_req_ready) begin
          w_state_next     = ST_WAIT;
          w_cnt_next       = CNT_LOAD;
          w_line_base_next = {s_bus.add_in[31:6], 6'b0};
          if (r_req_count != 16'hFFFF) begin
            w_req_count_next = r_req_count + 16'd1;
          end
        end
      end

      ST_WAIT: begin
        // Counter loaded with LATENCY-1 at accept; leaving on the edge where
        // it reads zero puts resp_valid up exactly LATENCY edges after accept.
        if (r_cnt == 4'd0) begin
          w_state_next = ST_RESP;
        end else begin
          w_cnt_next = r_cnt - 4'd1;
        end
      end

      ST_RESP: begin
        // resp_valid is the registered image of being in RESP, so resp_ready
        // alone completes the handshake here.
        if (s_bus.resp_ready) begin
          w_state_next = ST_IDLE;
        end
      end

      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Outputs are computed from the state being entered so the registered
  // copies line up with the state register on the same edge.
  always_comb begin
    w_req_ready_next  = (w_state_next == ST_IDLE);
    w_resp_valid_next = (w_state_next == ST_RESP);
    w_add_out_next    = 32'h0;
    w_d_out_next      = 512'h0;
    if (w_state_next == ST_RESP) begin
      // line_base is only written on accept, so while in RESP these values
      // are recomputed from an unchanging base and stay stable.
      w_add_out_next = r_line_base;
      w_d_out_next   = w_line_data;
    end
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= ST_IDLE;
      r_cnt        <= 4'd0;
      r_line_base  <= 32'h0;
      r_req_count  <= 16'h0;
      r_req_ready  <= 1'b0;
      r_resp_valid <= 1'b0;
      r_d_out      <= 512'h0;
      r_add_out    <= 32'h0;
    end else begin
      r_state      <= w_state_next;
      r_cnt        <= w_cnt_next;
      r_line_base  <= w_line_base_next;
      r_req_count  <= w_req_count_next;
      r_req_ready  <= w_req_ready_next;
      r_resp_valid <= w_resp_valid_next;
      r_d_out      <= w_d_out_next;
      r_add_out    <= w_add_out_next;
    end
  end

  // -------------------------------------------------------------------------
  // Output drive
  // -------------------------------------------------------------------------
  assign s_bus.req_ready  = r_req_ready;
  assign s_bus.resp_valid = r_resp_valid;
  assign s_bus.d_out      = r_d_out;
  assign s_bus.add_out    = r_add_out;
  assign s_bus.req_count  = r_req_count;

endmodule : l2_stub

// File: tb/tb_l2_stub.sv
// ---------------------------------------------------------------------------
// tb_l2_stub
//
// Directed bench for l2_stub. Four instances cover the parameter space:
//   dut_a LATENCY=4 SEED=0          main function, hold, back-to-back, reset
//   dut_b LATENCY=2 SEED=FFFF_FFFF  seed masking and latency 2
//   dut_c LATENCY=0 SEED=0          zero latency behaves as one
//   dut_d LATENCY=1 SEED=0          latency one, address wrap, saturation
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_l2_stub;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  l2_stub_if bus_a ();
  l2_stub_if bus_b ();
  l2_stub_if bus_c ();
  l2_stub_if bus_d ();

  l2_stub #(.LATENCY(4), .SEED(32'h0000_0000)) dut_a (.i_clk(clk), .i_rst_n(rst_n), .s_bus(bus_a));
  l2_stub #(.LATENCY(2), .SEED(32'hFFFF_FFFF)) dut_b (.i_clk(clk), .i_rst_n(rst_n), .s_bus(bus_b));
  l2_stub #(.LATENCY(0), .SEED(32'h0000_0000)) dut_c (.i_clk(clk), .i_rst_n(rst_n), .s_bus(bus_c));
  l2_stub #(.LATENCY(1), .SEED(32'h0000_0000)) dut_d (.i_clk(clk), .i_rst_n(rst_n), .s_bus(bus_d));

  task automatic idle_all();
    bus_a.req_valid = 1'b0; bus_a.add_in = 32'h0; bus_a.resp_ready = 1'b0;
    bus_b.req_valid = 1'b0; bus_b.add_in = 32'h0; bus_b.resp_ready = 1'b0;
    bus_c.req_valid = 1'b0; bus_c.add_in = 32'h0; bus_c.resp_ready = 1'b0;
    bus_d.req_valid = 1'b0; bus_d.add_in = 32'h0; bus_d.resp_ready = 1'b0;
  endtask

  // One full request/response on dut_d (LATENCY=1): accept, response on the
  // next edge, handshake on the one after. Leaves dut_d back in IDLE.
  task automatic d_txn(input logic [31:0] addr);
    @(negedge clk); bus_d.req_valid = 1'b1; bus_d.add_in = addr;
    @(negedge clk); bus_d.req_valid = 1'b0; bus_d.add_in = 32'h0;
    @(negedge clk); bus_d.resp_ready = 1'b1;
    @(negedge clk); bus_d.resp_ready = 1'b0;
    $display("txn d addr=%h count=%h", addr, bus_d.req_count);
  endtask

  // -------------------------------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b0;
    idle_all();
    #12;
    vectors++; if (bus_a.req_ready !== 1'b0)    begin miscompares++; $display("FAIL reset_req_ready: got %0b want 0", bus_a.req_ready); end
    vectors++; if (bus_a.resp_valid !== 1'b0)   begin miscompares++; $display("FAIL reset_resp_valid: got %0b want 0", bus_a.resp_valid); end
    vectors++; if (bus_a.d_out !== 512'h0)      begin miscompares++; $display("FAIL reset_d_out: got %h want 0", bus_a.d_out); end
    vectors++; if (bus_a.add_out !== 32'h0)     begin miscompares++; $display("FAIL reset_add_out: got %h want 0", bus_a.add_out); end
    vectors++; if (bus_a.req_count !== 16'h0)   begin miscompares++; $display("FAIL reset_req_count: got %h want 0", bus_a.req_count); end
    @(negedge clk); rst_n = 1'b1; #1;
    vectors++; if (bus_a.req_ready !== 1'b0)    begin miscompares++; $display("FAIL reset_ready_before_edge: got %0b want 0", bus_a.req_ready); end
    @(negedge clk);
    vectors++; if (bus_a.req_ready !== 1'b1)    begin miscompares++; $display("FAIL reset_ready_after_edge: got %0b want 1", bus_a.req_ready); end
    vectors++; if (bus_d.req_ready !== 1'b1)    begin miscompares++; $display("FAIL reset_ready_d: got %0b want 1", bus_d.req_ready); end
    $display("txn reset released");
  endtask

  // -------------------------------------------------------------------------
  task automatic test_basic();
    logic [511:0] exp_line;
    for (int i = 0; i < 16; i++) exp_line[32*i +: 32] = 32'h0000_1200 + 32'(4 * i);
    @(negedge clk); bus_a.req_valid = 1'b1; bus_a.add_in = 32'h0000_1234;
    @(negedge clk); bus_a.req_valid = 1'b0; bus_a.add_in = 32'hDEAD_BEEF;
    vectors++; if (bus_a.req_ready !== 1'b0)     begin miscompares++; $display("FAIL basic_wait_ready: got %0b want 0", bus_a.req_ready); end
    vectors++; if (bus_a.req_count !== 16'd1)    begin miscompares++; $display("FAIL basic_count: got %h want 1", bus_a.req_count); end
    vectors++; if (bus_a.add_out !== 32'h0)      begin miscompares++; $display("FAIL basic_wait_add_out: got %h want 0", bus_a.add_out); end
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      vectors++; if (bus_a.resp_valid !== 1'b0)  begin miscompares++; $display("FAIL basic_early_resp: edge k+%0d got %0b want 0", i, bus_a.resp_valid); end
    end
    @(negedge clk);
    vectors++; if (bus_a.resp_valid !== 1'b1)    begin miscompares++; $display("FAIL basic_resp_at_k4: got %0b want 1", bus_a.resp_valid); end
    vectors++; if (bus_a.add_out !== 32'h0000_1200) begin miscompares++; $display("FAIL basic_add_out: got %h want 00001200", bus_a.add_out); end
    vectors++; if (bus_a.d_out[31:0] !== 32'h0000_1200) begin miscompares++; $display("FAIL basic_word0: got %h want 00001200", bus_a.d_out[31:0]); end
    vectors++; if (bus_a.d_out[511:480] !== 32'h0000_123C) begin miscompares++; $display("FAIL basic_word15: got %h want 0000123c", bus_a.d_out[511:480]); end
    vectors++; if (bus_a.d_out !== exp_line)     begin miscompares++; $display("FAIL basic_line: got %h want %h", bus_a.d_out, exp_line); end
    vectors++; if (bus_a.req_ready !== 1'b0)     begin miscompares++; $display("FAIL basic_resp_ready: got %0b want 0", bus_a.req_ready); end
    bus_a.resp_ready = 1'b1;
    @(negedge clk); bus_a.resp_ready = 1'b0;
    vectors++; if (bus_a.resp_valid !== 1'b0)    begin miscompares++; $display("FAIL basic_after_hs_valid: got %0b want 0", bus_a.resp_valid); end
    vectors++; if (bus_a.req_ready !== 1'b1)     begin miscompares++; $display("FAIL basic_after_hs_ready: got %0b want 1", bus_a.req_ready); end
    vectors++; if (bus_a.d_out !== 512'h0)       begin miscompares++; $display("FAIL basic_after_hs_d_out: got %h want 0", bus_a.d_out); end
    vectors++; if (bus_a.add_out !== 32'h0)      begin miscompares++; $display("FAIL basic_after_hs_add_out: got %h want 0", bus_a.add_out); end
    $display("txn a addr=00001234 line=00001200");
  endtask

  // -------------------------------------------------------------------------
  task automatic test_seed();
    int lat;
    @(negedge clk); bus_b.req_valid = 1'b1; bus_b.add_in = 32'h0000_0040;
    @(negedge clk); bus_b.req_valid = 1'b0; bus_b.add_in = 32'h0;
    lat = 0;
    while (bus_b.resp_valid !== 1'b1 && lat < 20) begin @(negedge clk); lat++; end
    vectors++; if (lat != 2)                     begin miscompares++; $display("FAIL seed_latency: got %0d want 2", lat); end
    vectors++; if (bus_b.add_out !== 32'h0000_0040) begin miscompares++; $display("FAIL seed_add_out: got %h want 00000040", bus_b.add_out); end
    vectors++; if (bus_b.d_out[31:0] !== 32'hFFFF_FFBF) begin miscompares++; $display("FAIL seed_word0: got %h want ffffffbf", bus_b.d_out[31:0]); end
    vectors++; if (bus_b.d_out[63:32] !== 32'hFFFF_FFBB) begin miscompares++; $display("FAIL seed_word1: got %h want ffffffbb", bus_b.d_out[63:32]); end
    bus_b.resp_ready = 1'b1;
    @(negedge clk); bus_b.resp_ready = 1'b0;
    vectors++; if (bus_b.resp_valid !== 1'b0)    begin miscompares++; $display("FAIL seed_after_hs: got %0b want 0", bus_b.resp_valid); end
    $display("txn b addr=00000040 latency=%0d", lat);
  endtask

  // -------------------------------------------------------------------------
  task automatic test_hold();
    logic [511:0] exp_line;
    int stable_bad;
    for (int i = 0; i < 16; i++) exp_line[32*i +: 32] = 32'h0000_ABC0 + 32'(4 * i);
    @(negedge clk); bus_a.req_valid = 1'b1; bus_a.add_in = 32'h0000_ABCD;
    // resp_ready high during the first WAIT cycles must have no effect.
    @(negedge clk); bus_a.req_valid = 1'b0; bus_a.add_in = 32'h0; bus_a.resp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk); bus_a.resp_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    vectors++; if (bus_a.resp_valid !== 1'b1)    begin miscompares++; $display("FAIL hold_resp_arrives: got %0b want 1", bus_a.resp_valid); end
    vectors++; if (bus_a.req_count !== 16'd2)    begin miscompares++; $display("FAIL hold_count_before: got %h want 2", bus_a.req_count); end
    stable_bad = 0;
    for (int i = 0; i < 10; i++) begin
      bus_a.req_valid = i[0]; bus_a.add_in = $urandom;
      @(negedge clk);
      if (bus_a.resp_valid !== 1'b1 || bus_a.add_out !== 32'h0000_ABC0 ||
          bus_a.d_out !== exp_line || bus_a.req_ready !== 1'b0 || bus_a.req_count !== 16'd2) stable_bad++;
    end
    bus_a.req_valid = 1'b0;
    vectors++; if (stable_bad != 0)              begin miscompares++; $display("FAIL hold_stable: got %0d bad cycles want 0 (add_out=%h count=%h)", stable_bad, bus_a.add_out, bus_a.req_count); end
    bus_a.resp_ready = 1'b1;
    @(negedge clk); bus_a.resp_ready = 1'b0;
    vectors++; if (bus_a.req_count !== 16'd2)    begin miscompares++; $display("FAIL hold_count_after: got %h want 2", bus_a.req_count); end
    vectors++; if (bus_a.req_ready !== 1'b1)     begin miscompares++; $display("FAIL hold_ready_after: got %0b want 1", bus_a.req_ready); end
    $display("txn a addr=0000abcd held 10 cycles");
  endtask

  // -------------------------------------------------------------------------
  task automatic test_wrap();
    @(negedge clk);
    bus_c.req_valid = 1'b1; bus_c.add_in = 32'hFFFF_FFC4;
    bus_d.req_valid = 1'b1; bus_d.add_in = 32'hFFFF_FFC4;
    @(negedge clk);
    bus_c.req_valid = 1'b0; bus_d.req_valid = 1'b0;
    vectors++; if (bus_c.resp_valid !== 1'b0 || bus_c.req_ready !== 1'b0) begin miscompares++; $display("FAIL wrap_c_wait: got valid=%0b ready=%0b want 0 0", bus_c.resp_valid, bus_c.req_ready); end
    vectors++; if (bus_d.resp_valid !== 1'b0 || bus_d.req_ready !== 1'b0) begin miscompares++; $display("FAIL wrap_d_wait: got valid=%0b ready=%0b want 0 0", bus_d.resp_valid, bus_d.req_ready); end
    @(negedge clk);
    vectors++; if (bus_d.resp_valid !== 1'b1)    begin miscompares++; $display("FAIL wrap_d_latency1: got %0b want 1", bus_d.resp_valid); end
    vectors++; if (bus_c.resp_valid !== 1'b1)    begin miscompares++; $display("FAIL wrap_c_latency0: got %0b want 1", bus_c.resp_valid); end
    vectors++; if (bus_d.add_out !== 32'hFFFF_FFC0) begin miscompares++; $display("FAIL wrap_add_out: got %h want ffffffc0", bus_d.add_out); end
    vectors++; if (bus_d.d_out[31:0] !== 32'hFFFF_FFC0) begin miscompares++; $display("FAIL wrap_word0: got %h want ffffffc0", bus_d.d_out[31:0]); end
    vectors++; if (bus_d.d_out[511:480] !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL wrap_word15: got %h want fffffffc", bus_d.d_out[511:480]); end
    vectors++; if (bus_c.d_out[511:480] !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL wrap_c_word15: got %h want fffffffc", bus_c.d_out[511:480]); end
    bus_c.resp_ready = 1'b1; bus_d.resp_ready = 1'b1;
    @(negedge clk);
    bus_c.resp_ready = 1'b0; bus_d.resp_ready = 1'b0;
    vectors++; if (bus_d.req_ready !== 1'b1 || bus_c.req_ready !== 1'b1) begin miscompares++; $display("FAIL wrap_back_idle: got c=%0b d=%0b want 1 1", bus_c.req_ready, bus_d.req_ready); end
    $display("txn c,d addr=ffffffc4 line=ffffffc0");
  endtask

  // -------------------------------------------------------------------------
  task automatic test_back_to_back();
    int gap;
    int wait_cyc;
    @(negedge clk); bus_a.req_valid = 1'b1; bus_a.add_in = 32'h0000_0100; bus_a.resp_ready = 1'b1;
    @(negedge clk); bus_a.add_in = 32'h0000_0200;
    vectors++; if (bus_a.req_count !== 16'd3)    begin miscompares++; $display("FAIL b2b_first_count: got %h want 3", bus_a.req_count); end
    gap = 0;
    while (bus_a.req_count !== 16'd4 && gap < 30) begin @(negedge clk); gap++; end
    bus_a.req_valid = 1'b0; bus_a.resp_ready = 1'b0;
    // accept e0, RESP at e0+4, handshake e0+5, ready at e0+5, accept e0+6
    vectors++; if (gap != 6)                     begin miscompares++; $display("FAIL b2b_spacing: got %0d want 6", gap); end
    wait_cyc = 0;
    while (bus_a.resp_valid !== 1'b1 && wait_cyc < 20) begin @(negedge clk); wait_cyc++; end
    vectors++; if (bus_a.add_out !== 32'h0000_0200) begin miscompares++; $display("FAIL b2b_second_addr: got %h want 00000200", bus_a.add_out); end
    vectors++; if (wait_cyc != 4)                begin miscompares++; $display("FAIL b2b_second_latency: got %0d want 4", wait_cyc); end
    bus_a.resp_ready = 1'b1;
    @(negedge clk); bus_a.resp_ready = 1'b0;
    $display("txn a b2b 00000100,00000200 gap=%0d", gap);
  endtask

  // -------------------------------------------------------------------------
  task automatic test_reset_mid_wait();
    int seen;
    @(negedge clk); bus_a.req_valid = 1'b1; bus_a.add_in = 32'h0000_3000;
    @(negedge clk); bus_a.req_valid = 1'b0;
    @(negedge clk);
    #2; rst_n = 1'b0; #1;
    vectors++; if (bus_a.req_ready !== 1'b0 || bus_a.resp_valid !== 1'b0) begin miscompares++; $display("FAIL rstwait_handshake: got ready=%0b valid=%0b want 0 0", bus_a.req_ready, bus_a.resp_valid); end
    vectors++; if (bus_a.req_count !== 16'h0)    begin miscompares++; $display("FAIL rstwait_count: got %h want 0", bus_a.req_count); end
    vectors++; if (bus_a.add_out !== 32'h0 || bus_a.d_out !== 512'h0) begin miscompares++; $display("FAIL rstwait_data: got add_out=%h want 0", bus_a.add_out); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    vectors++; if (bus_a.req_ready !== 1'b1)     begin miscompares++; $display("FAIL rstwait_ready: got %0b want 1", bus_a.req_ready); end
    vectors++; if (bus_a.req_count !== 16'h0)    begin miscompares++; $display("FAIL rstwait_count_after: got %h want 0", bus_a.req_count); end
    seen = 0;
    for (int i = 0; i < 8; i++) begin @(negedge clk); if (bus_a.resp_valid !== 1'b0) seen++; end
    vectors++; if (seen != 0)                    begin miscompares++; $display("FAIL rstwait_no_resp: got %0d valid cycles want 0", seen); end
    $display("txn a addr=00003000 discarded by reset");
  endtask

  // -------------------------------------------------------------------------
  task automatic test_saturate();
    d_txn(32'h0000_0500);
    vectors++; if (bus_d.req_count !== 16'd1)    begin miscompares++; $display("FAIL sat_first: got %h want 1", bus_d.req_count); end
    // Stand in for 65534 earlier accepts rather than simulating them.
    @(negedge clk);
    force dut_d.r_req_count = 16'hFFFE;
    #1;
    release dut_d.r_req_count;
    d_txn(32'h0000_0600);
    vectors++; if (bus_d.req_count !== 16'hFFFF) begin miscompares++; $display("FAIL sat_reach: got %h want ffff", bus_d.req_count); end
    d_txn(32'h0000_0700);
    vectors++; if (bus_d.req_count !== 16'hFFFF) begin miscompares++; $display("FAIL sat_hold1: got %h want ffff", bus_d.req_count); end
    d_txn(32'h0000_0800);
    vectors++; if (bus_d.req_count !== 16'hFFFF) begin miscompares++; $display("FAIL sat_hold2: got %h want ffff", bus_d.req_count); end
  endtask

  // -------------------------------------------------------------------------
  initial begin
    test_reset();
    test_basic();
    test_seed();
    test_hold();
    test_wrap();
    test_back_to_back();
    test_reset_mid_wait();
    test_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

endmodule : tb_l2_stub
